// File: rtl/pipeline_trace_tagger_if.sv
// pipeline_trace_tagger_if
// Groups the fetch/hazard controls and the trace outputs of the pipeline
// trace tagger into a single bundle.
//   master : pipeline side; drives fetch_valid/fetch_pc/stall/flush, observes trace
//   slave  : the tagger itself; consumes controls, drives stage tags and retire record
// Optional macro TRACE_FLUSH_REPORT_EN adds kill_valid/kill_id/kill_pc.
interface pipeline_trace_tagger_if #(
    parameter int ID_W  = 8,
    parameter int CYC_W = 16,
    parameter int PC_W  = 16
);
    logic              fetch_valid;
    logic [PC_W-1:0]   fetch_pc;
    logic              stall;
    logic              flush;

    logic              if_valid;
    logic              id_valid;
    logic              ex_valid;
    logic              mem_valid;
    logic              wb_valid;
    logic [ID_W-1:0]   if_id;
    logic [ID_W-1:0]   id_id;
    logic [ID_W-1:0]   ex_id;
    logic [ID_W-1:0]   mem_id;
    logic [ID_W-1:0]   wb_id;

    logic [CYC_W-1:0]  cycle;

    logic              retire_valid;
    logic [PC_W-1:0]   retire_pc;
    logic [CYC_W-1:0]  retire_if_cyc;
    logic [CYC_W-1:0]  retire_id_cyc;
    logic [CYC_W-1:0]  retire_ex_cyc;
    logic [CYC_W-1:0]  retire_mem_cyc;
    logic [CYC_W-1:0]  retire_wb_cyc;
    logic [3:0]        retire_stalls;
    logic [31:0]       retired_count;

`ifdef TRACE_FLUSH_REPORT_EN
    logic              kill_valid;
    logic [ID_W-1:0]   kill_id;
    logic [PC_W-1:0]   kill_pc;
`endif

    modport master (
        output fetch_valid, fetch_pc, stall, flush,
        input  if_valid, id_valid, ex_valid, mem_valid, wb_valid,
        input  if_id, id_id, ex_id, mem_id, wb_id,
        input  cycle,
        input  retire_valid, retire_pc,
        input  retire_if_cyc, retire_id_cyc, retire_ex_cyc, retire_mem_cyc, retire_wb_cyc,
        input  retire_stalls, retired_count
`ifdef TRACE_FLUSH_REPORT_EN
        ,
        input  kill_valid, kill_id, kill_pc
`endif
    );

    modport slave (
        input  fetch_valid, fetch_pc, stall, flush,
        output if_valid, id_valid, ex_valid, mem_valid, wb_valid,
        output if_id, id_id, ex_id, mem_id, wb_id,
        output cycle,
        output retire_valid, retire_pc,
        output retire_if_cyc, retire_id_cyc, retire_ex_cyc, retire_mem_cyc, retire_wb_cyc,
        output retire_stalls, retired_count
`ifdef TRACE_FLUSH_REPORT_EN
        ,
        output kill_valid, kill_id, kill_pc
`endif
    );
endinterface

// File: rtl/pipeline_trace_tagger.sv
// pipeline_trace_tagger
// Shadows the 5-stage CPU pipeline (IF, ID, EX, MEM, WB) with trace records.
// Each fetched instruction gets a sequence ID and collects the cycle it first
// entered every stage plus the number of cycles it was held in ID by a stall.
// The WB record is presented combinationally as the retire record.
// Ports:
//   clk  : system clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   tif  : pipeline_trace_tagger_if.slave (fetch/stall/flush in, stage tags,
//          cycle counter, retire record and retired count out)
// Optional macro TRACE_FLUSH_REPORT_EN: registered report of the IF record
// killed by a flush (kill_valid/kill_id/kill_pc).
module pipeline_trace_tagger #(
    parameter int ID_W  = 8,
    parameter int CYC_W = 16,
    parameter int PC_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_trace_tagger_if.slave  tif
);

    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]  ID_ONE  = {{(ID_W-1){1'b0}}, 1'b1};

    // One trace record per pipeline stage. Stamps of stages not yet reached
    // stay zero; a bubble is the all-zero record.
    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [PC_W-1:0]   pc;
        logic [CYC_W-1:0]  if_cyc;
        logic [CYC_W-1:0]  id_cyc;
        logic [CYC_W-1:0]  ex_cyc;
        logic [CYC_W-1:0]  mem_cyc;
        logic [CYC_W-1:0]  wb_cyc;
        logic [3:0]        stalls;
    } rec_t;

    rec_t              if_q,  if_d;
    rec_t              id_q,  id_d;
    rec_t              ex_q,  ex_d;
    rec_t              mem_q, mem_d;
    rec_t              wb_q,  wb_d;
    logic [ID_W-1:0]   next_id_q, next_id_d;
    logic [CYC_W-1:0]  cycle_q, cycle_d;
    logic [31:0]       retired_count_q, retired_count_d;
    logic [CYC_W-1:0]  cyc_next;

    always_comb begin
        // A record written at this edge is first seen in the next cycle,
        // so its stamp is the value the counter is about to take.
        cyc_next        = cycle_q + CYC_ONE;
        cycle_d         = cyc_next;
        next_id_d       = next_id_q;
        retired_count_d = retired_count_q + {31'd0, wb_q.valid};

        if_d  = if_q;
        id_d  = id_q;

        // MEM and WB advance regardless of stall.
        wb_d = mem_q;
        if (mem_q.valid) begin
            wb_d.wb_cyc = cyc_next;
        end
        mem_d = ex_q;
        if (ex_q.valid) begin
            mem_d.mem_cyc = cyc_next;
        end

        if (tif.stall) begin
            // IF/ID hold; flush and fetch are ignored while stalled.
            ex_d = '0;
            if (id_q.valid && (id_q.stalls != 4'hF)) begin
                id_d.stalls = id_q.stalls + 4'd1;
            end
        end else begin
            ex_d = id_q;
            if (id_q.valid) begin
                ex_d.ex_cyc = cyc_next;
            end

            if (tif.flush) begin
                id_d = '0;
            end else begin
                id_d = if_q;
                if (if_q.valid) begin
                    id_d.id_cyc = cyc_next;
                end
            end

            if_d = '0;
            if (tif.fetch_valid) begin
                if_d.valid  = 1'b1;
                if_d.id     = next_id_q;
                if_d.pc     = tif.fetch_pc;
                if_d.if_cyc = cyc_next;
                next_id_d   = next_id_q + ID_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_q            <= '0;
            id_q            <= '0;
            ex_q            <= '0;
            mem_q           <= '0;
            wb_q            <= '0;
            next_id_q       <= '0;
            cycle_q         <= '0;
            retired_count_q <= '0;
        end else begin
            if_q            <= if_d;
            id_q            <= id_d;
            ex_q            <= ex_d;
            mem_q           <= mem_d;
            wb_q            <= wb_d;
            next_id_q       <= next_id_d;
            cycle_q         <= cycle_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign tif.if_valid       = if_q.valid;
    assign tif.id_valid       = id_q.valid;
    assign tif.ex_valid       = ex_q.valid;
    assign tif.mem_valid      = mem_q.valid;
    assign tif.wb_valid       = wb_q.valid;
    assign tif.if_id          = if_q.id;
    assign tif.id_id          = id_q.id;
    assign tif.ex_id          = ex_q.id;
    assign tif.mem_id         = mem_q.id;
    assign tif.wb_id          = wb_q.id;
    assign tif.cycle          = cycle_q;

    assign tif.retire_valid   = wb_q.valid;
    assign tif.retire_pc      = wb_q.pc;
    assign tif.retire_if_cyc  = wb_q.if_cyc;
    assign tif.retire_id_cyc  = wb_q.id_cyc;
    assign tif.retire_ex_cyc  = wb_q.ex_cyc;
    assign tif.retire_mem_cyc = wb_q.mem_cyc;
    assign tif.retire_wb_cyc  = wb_q.wb_cyc;
    assign tif.retire_stalls  = wb_q.stalls;
    assign tif.retired_count  = retired_count_q;

`ifdef TRACE_FLUSH_REPORT_EN
    logic              kill_valid_q, kill_valid_d;
    logic [ID_W-1:0]   kill_id_q,    kill_id_d;
    logic [PC_W-1:0]   kill_pc_q,    kill_pc_d;

    // A flush only kills something when it is honoured (no stall) and IF
    // actually holds an instruction. The killed ID is not handed out again.
    always_comb begin
        kill_valid_d = 1'b0;
        kill_id_d    = '0;
        kill_pc_d    = '0;
        if (tif.flush && !tif.stall && if_q.valid) begin
            kill_valid_d = 1'b1;
            kill_id_d    = if_q.id;
            kill_pc_d    = if_q.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kill_valid_q <= 1'b0;
            kill_id_q    <= '0;
            kill_pc_q    <= '0;
        end else begin
            kill_valid_q <= kill_valid_d;
            kill_id_q    <= kill_id_d;
            kill_pc_q    <= kill_pc_d;
        end
    end

    assign tif.kill_valid = kill_valid_q;
    assign tif.kill_id    = kill_id_q;
    assign tif.kill_pc    = kill_pc_q;
`endif

endmodule

// File: tb/tb_pipeline_trace_tagger.sv
// Testbench for pipeline_trace_tagger: directed and random fetch/stall/flush/reset
// traffic compared every cycle against an instruction-list reference model.
module tb_pipeline_trace_tagger;

    localparam int ID_W  = 8;
    localparam int CYC_W = 16;
    localparam int PC_W  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_trace_tagger_if #(.ID_W(ID_W), .CYC_W(CYC_W), .PC_W(PC_W)) tif();

    pipeline_trace_tagger #(.ID_W(ID_W), .CYC_W(CYC_W), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    // Reference model: the list of in-flight instructions, each knowing which
    // stage it sits in (0=IF .. 4=WB) and the cycle it entered each stage.
    typedef struct {
        int id;
        int pc;
        int cyc[5];
        int stalls;
        int stage;
    } inst_t;

    inst_t       pipe[$];
    int          m_cycle;
    int          m_next_id;
    int unsigned m_retired;
    int          m_kill_v, m_kill_id, m_kill_pc;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int find_stage(input int s);
        foreach (pipe[i]) if (pipe[i].stage == s) return i;
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit fv, input int pc, input bit st, input bit fl);
        inst_t keep[$];
        inst_t n;
        int    nc;
        m_kill_v  = 0;
        m_kill_id = 0;
        m_kill_pc = 0;
        if (r) begin
            pipe.delete();
            m_cycle   = 0;
            m_next_id = 0;
            m_retired = 0;
            return;
        end
        nc = (m_cycle + 1) % (1 << CYC_W);
        foreach (pipe[i]) begin
            inst_t x;
            x = pipe[i];
            if (x.stage == 4) begin
                m_retired++;
                continue;
            end
            if (st) begin
                if (x.stage >= 2) begin
                    x.stage++;
                    x.cyc[x.stage] = nc;
                end else if (x.stage == 1 && x.stalls < 15) begin
                    x.stalls++;
                end
            end else begin
                if (x.stage == 0 && fl) begin
                    m_kill_v  = 1;
                    m_kill_id = x.id;
                    m_kill_pc = x.pc;
                    continue;
                end
                x.stage++;
                x.cyc[x.stage] = nc;
            end
            keep.push_back(x);
        end
        if (!st && fv) begin
            n.id     = m_next_id;
            n.pc     = pc;
            n.cyc    = '{nc, 0, 0, 0, 0};
            n.stalls = 0;
            n.stage  = 0;
            keep.push_back(n);
            m_next_id = (m_next_id + 1) % (1 << ID_W);
        end
        pipe    = keep;
        m_cycle = nc;
    endtask

    task automatic compare_all();
        logic [4:0]      dv;
        logic [ID_W-1:0] did[5];
        int              k;
        dv  = {tif.wb_valid, tif.mem_valid, tif.ex_valid, tif.id_valid, tif.if_valid};
        did = '{tif.if_id, tif.id_id, tif.ex_id, tif.mem_id, tif.wb_id};
        check("cycle", 32'(tif.cycle), 32'(m_cycle));
        for (int s = 0; s < 5; s++) begin
            k = find_stage(s);
            check($sformatf("valid[%0d]", s), 32'(dv[s]), (k >= 0) ? 32'd1 : 32'd0);
            check($sformatf("id[%0d]", s), 32'(did[s]), (k >= 0) ? 32'(pipe[k].id) : 32'd0);
        end
        k = find_stage(4);
        check("retire_valid", 32'(tif.retire_valid), (k >= 0) ? 32'd1 : 32'd0);
        check("retire_pc", 32'(tif.retire_pc), (k >= 0) ? 32'(pipe[k].pc) : 32'd0);
        check("retire_if_cyc", 32'(tif.retire_if_cyc), (k >= 0) ? 32'(pipe[k].cyc[0]) : 32'd0);
        check("retire_id_cyc", 32'(tif.retire_id_cyc), (k >= 0) ? 32'(pipe[k].cyc[1]) : 32'd0);
        check("retire_ex_cyc", 32'(tif.retire_ex_cyc), (k >= 0) ? 32'(pipe[k].cyc[2]) : 32'd0);
        check("retire_mem_cyc", 32'(tif.retire_mem_cyc), (k >= 0) ? 32'(pipe[k].cyc[3]) : 32'd0);
        check("retire_wb_cyc", 32'(tif.retire_wb_cyc), (k >= 0) ? 32'(pipe[k].cyc[4]) : 32'd0);
        check("retire_stalls", 32'(tif.retire_stalls), (k >= 0) ? 32'(pipe[k].stalls) : 32'd0);
        check("retired_count", tif.retired_count, m_retired);
`ifdef TRACE_FLUSH_REPORT_EN
        check("kill_valid", 32'(tif.kill_valid), 32'(m_kill_v));
        check("kill_id", 32'(tif.kill_id), 32'(m_kill_id));
        check("kill_pc", 32'(tif.kill_pc), 32'(m_kill_pc));
`endif
    endtask

    // Inputs change away from the active edge, the model advances on the
    // same edge as the DUT, and outputs are compared on the falling edge.
    task automatic step(input bit r, input bit fv, input int pc, input bit st, input bit fl);
        rst             = r;
        tif.fetch_valid = fv;
        tif.fetch_pc    = PC_W'(pc);
        tif.stall       = st;
        tif.flush       = fl;
        @(posedge clk);
        model_step(r, fv, pc, st, fl);
        @(negedge clk);
        compare_all();
    endtask

    int pc_seq;

    initial begin
        rst             = 1'b1;
        tif.fetch_valid = 1'b0;
        tif.fetch_pc    = '0;
        tif.stall       = 1'b0;
        tif.flush       = 1'b0;
        pc_seq          = 0;

        // reset and basic in-order flow
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 'h0, 0, 0);
        step(0, 1, 'h2, 0, 0);
        step(0, 1, 'h4, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0);

        // two-cycle stall with an instruction in ID
        step(0, 1, 'h10, 0, 0);
        step(0, 1, 'h12, 0, 0);
        step(0, 1, 'h14, 1, 0);
        step(0, 1, 'h14, 1, 0);
        step(0, 1, 'h14, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0);

        // flush of a valid IF record, then stall+flush together
        step(0, 1, 'h20, 0, 0);
        step(0, 1, 'h22, 0, 0);
        step(0, 1, 'h24, 0, 1);
        step(0, 1, 'h26, 0, 0);
        step(0, 1, 'h28, 1, 1);
        step(0, 1, 'h28, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 0);

        // long stall saturating the stall counter
        step(0, 1, 'h30, 0, 0);
        step(0, 1, 'h32, 0, 0);
        repeat (18) step(0, 0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0, 0);

        // unbroken fetch run wrapping the sequence ID
        for (int i = 0; i < 270; i++) begin
            step(0, 1, pc_seq, 0, 0);
            pc_seq = (pc_seq + 2) % (1 << PC_W);
        end
        repeat (6) step(0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            step(0, ($urandom_range(0, 9) < 8), $urandom_range(0, (1 << PC_W) - 1),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2));
        end

        // reset with instructions in flight, then restart
        repeat (4) step(0, 1, $urandom_range(0, (1 << PC_W) - 1), 0, 0);
        step(1, 1, 'h40, 0, 0);
        step(0, 1, 'h50, 0, 0);
        step(0, 1, 'h52, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 $urandom_range(0, (1 << PC_W) - 1),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
